// File: rtl/spwm_deadtime.sv
// rtl/spwm_deadtime.sv - complementary gate drive with dead time, min ON width, fault latch and drop counter
module spwm_deadtime #(
    parameter int DT_W   = 8,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              pwm_in,
    input  logic [DT_W-1:0]   dead_time,
    input  logic [DT_W-1:0]   min_on,
    input  logic              fault_in,
    input  logic              fault_clr,
    output logic              hs_out,
    output logic              ls_out,
    output logic              fault,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_DT_TO_LS,
        ST_LS_ON,
        ST_DT_TO_HS,
        ST_HS_ON,
        ST_FAULT
    } state_t;

    localparam logic [DT_W-1:0]   DT_ONE   = DT_W'(1);
    localparam logic [DT_W-1:0]   DT_MAX   = '1;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    state_t              state_q, state_d;
    logic [DT_W-1:0]     dt_cnt_q, dt_cnt_d;
    logic [DT_W-1:0]     on_cnt_q, on_cnt_d;
    logic                pend_q, pend_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                fault_q, fault_d;
    logic                hs_q, ls_q;

    logic [DT_W-1:0]     dt_load;
    logic                mismatch;
    logic                min_met;

    // A zero dead time still costs one cycle so the two drives never overlap
    assign dt_load  = (dead_time == '0) ? DT_ONE : dead_time;
    assign mismatch = ((state_q == ST_HS_ON) && !pwm_in) || ((state_q == ST_LS_ON) && pwm_in);
    assign min_met  = (on_cnt_q >= min_on);

    // Next-state and counter update; priority is fault_in, then en, then normal flow
    always_comb begin
        state_d  = state_q;
        dt_cnt_d = dt_cnt_q;
        on_cnt_d = on_cnt_q;
        pend_d   = pend_q;
        drop_d   = drop_q;
        fault_d  = fault_q;

        if (fault_in) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            pend_d  = 1'b0;
        end else if (state_q == ST_FAULT) begin
            // fault_in is known low here, so fault_clr alone releases the latch
            if (fault_clr) begin
                state_d = ST_OFF;
                fault_d = 1'b0;
            end
        end else if (!en) begin
            state_d = ST_OFF;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d  = pwm_in ? ST_DT_TO_HS : ST_DT_TO_LS;
                    dt_cnt_d = dt_load;
                end
                ST_DT_TO_LS, ST_DT_TO_HS: begin
                    // Target was fixed at entry; pwm_in is ignored until the ON state
                    if (dt_cnt_q <= DT_ONE) begin
                        state_d  = (state_q == ST_DT_TO_HS) ? ST_HS_ON : ST_LS_ON;
                        on_cnt_d = '0;
                        pend_d   = 1'b0;
                    end else begin
                        dt_cnt_d = dt_cnt_q - DT_ONE;
                    end
                end
                ST_HS_ON, ST_LS_ON: begin
                    if (mismatch && min_met) begin
                        state_d  = (state_q == ST_HS_ON) ? ST_DT_TO_LS : ST_DT_TO_HS;
                        dt_cnt_d = dt_load;
                        pend_d   = 1'b0;
                    end else begin
                        if (on_cnt_q != DT_MAX) begin
                            on_cnt_d = on_cnt_q + DT_ONE;
                        end
                        // A request that goes away before the minimum width is a swallowed pulse
                        if (mismatch) begin
                            pend_d = 1'b1;
                        end else if (pend_q) begin
                            pend_d = 1'b0;
                            if (drop_q != DROP_MAX) begin
                                drop_d = drop_q + DROP_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    // State, counters and output drives all registered on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_OFF;
            dt_cnt_q <= '0;
            on_cnt_q <= '0;
            pend_q   <= 1'b0;
            drop_q   <= '0;
            fault_q  <= 1'b0;
            hs_q     <= 1'b0;
            ls_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            dt_cnt_q <= dt_cnt_d;
            on_cnt_q <= on_cnt_d;
            pend_q   <= pend_d;
            drop_q   <= drop_d;
            fault_q  <= fault_d;
            hs_q     <= (state_d == ST_HS_ON);
            ls_q     <= (state_d == ST_LS_ON);
        end
    end

    assign hs_out   = hs_q;
    assign ls_out   = ls_q;
    assign fault    = fault_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_spwm_deadtime.sv
// tb/tb_spwm_deadtime.sv - directed and soak bench for spwm_deadtime
module tb_spwm_deadtime;

    logic        clk;
    logic        rst;
    logic        en;
    logic        pwm_in;
    logic [7:0]  dead_time;
    logic [7:0]  min_on;
    logic        fault_in;
    logic        fault_clr;
    logic        hs_out;
    logic        ls_out;
    logic        fault;
    logic [15:0] drop_cnt;

    int n_assert;
    int n_fail;

    spwm_deadtime #(.DT_W(8), .DROP_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pwm_in    (pwm_in),
        .dead_time (dead_time),
        .min_on    (min_on),
        .fault_in  (fault_in),
        .fault_clr (fault_clr),
        .hs_out    (hs_out),
        .ls_out    (ls_out),
        .fault     (fault),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic exp_hs, input logic exp_ls);
        check({tag, "_hs"}, {31'b0, hs_out}, {31'b0, exp_hs});
        check({tag, "_ls"}, {31'b0, ls_out}, {31'b0, exp_ls});
    endtask

    initial begin
        logic cur_pwm;
        logic prev_on;
        logic in_gap;
        logic first_pulse;
        int   on_len;
        int   gap_len;
        int   gap_exp;
        int   cur_dt;
        int   cur_min;

        n_assert = 0;
        n_fail   = 0;

        // 1. reset with random inputs
        rst       = 1'b1;
        en        = 1'($urandom);
        pwm_in    = 1'($urandom);
        fault_in  = 1'($urandom);
        fault_clr = 1'($urandom);
        dead_time = 8'($urandom);
        min_on    = 8'($urandom);
        tick();
        tick();
        check_outs("rst", 1'b0, 1'b0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        check("rst_drop", {16'b0, drop_cnt}, 32'd0);
        rst       = 1'b0;
        en        = 1'b0;
        fault_in  = 1'b0;
        fault_clr = 1'b0;
        tick();
        tick();
        check_outs("en_off", 1'b0, 1'b0);

        // 2. startup into LS through a 4-cycle dead time
        en        = 1'b1;
        pwm_in    = 1'b0;
        dead_time = 8'd4;
        min_on    = 8'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_outs($sformatf("start_dt%0d", i), 1'b0, 1'b0);
        end
        tick();
        check_outs("start_ls", 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) tick();
        check_outs("ls_hold", 1'b0, 1'b1);

        // switch to HS: ls falls at the next edge, 4 dead cycles, then hs
        pwm_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_outs($sformatf("sw_dt%0d", i), 1'b0, 1'b0);
        end
        tick();
        check_outs("sw_hs", 1'b1, 1'b0);

        // 3. short pulse swallowed in LS_ON
        for (int i = 0; i < 6; i++) tick();
        min_on = 8'd5;
        pwm_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        tick();
        check_outs("sp_ls_entry", 1'b0, 1'b1);
        tick();
        pwm_in = 1'b1;
        tick();
        check_outs("sp_pulse", 1'b0, 1'b1);
        check("sp_drop0", {16'b0, drop_cnt}, 32'd0);
        pwm_in = 1'b0;
        tick();
        check_outs("sp_after", 1'b0, 1'b1);
        check("sp_drop1", {16'b0, drop_cnt}, 32'd1);

        // 4. zero dead time: single-cycle gap at every transition
        dead_time = 8'd0;
        min_on    = 8'd0;
        cur_pwm   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cur_pwm = ~cur_pwm;
            pwm_in  = cur_pwm;
            tick();
            check_outs($sformatf("z%0d_gap", k), 1'b0, 1'b0);
            tick();
            check_outs($sformatf("z%0d_on", k), cur_pwm, ~cur_pwm);
            tick();
            tick();
            check_outs($sformatf("z%0d_hold", k), cur_pwm, ~cur_pwm);
        end

        // 5. fault handling from HS_ON
        pwm_in = 1'b1;
        tick();
        tick();
        check_outs("f_pre_hs", 1'b1, 1'b0);
        fault_in = 1'b1;
        tick();
        check_outs("f_trip", 1'b0, 1'b0);
        check("f_trip_flag", {31'b0, fault}, 32'd1);
        fault_in = 1'b0;
        tick();
        check("f_sticky", {31'b0, fault}, 32'd1);
        check_outs("f_sticky", 1'b0, 1'b0);
        fault_in  = 1'b1;
        fault_clr = 1'b1;
        tick();
        check("f_clr_blocked", {31'b0, fault}, 32'd1);
        fault_in  = 1'b0;
        dead_time = 8'd4;
        tick();
        check("f_clr", {31'b0, fault}, 32'd0);
        check_outs("f_off", 1'b0, 1'b0);
        fault_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_outs($sformatf("f_dt%0d", i), 1'b0, 1'b0);
        end
        tick();
        check_outs("f_restart_hs", 1'b1, 1'b0);

        // 6. soak with random pwm, dead time and min width
        prev_on     = 1'b1;
        in_gap      = 1'b0;
        first_pulse = 1'b1;
        on_len      = 1;
        gap_len     = 0;
        gap_exp     = 0;
        for (int c = 0; c < 10000; c++) begin
            pwm_in    = 1'($urandom);
            dead_time = 8'($urandom_range(15, 0));
            min_on    = 8'($urandom_range(7, 0));
            cur_dt    = int'(dead_time);
            cur_min   = int'(min_on);
            tick();
            check("soak_overlap", {31'b0, hs_out & ls_out}, 32'd0);
            if (hs_out || ls_out) begin
                if (in_gap) begin
                    check("soak_gap", gap_len, gap_exp);
                    in_gap = 1'b0;
                    on_len = 1;
                end else begin
                    on_len++;
                end
                prev_on = 1'b1;
            end else begin
                if (prev_on) begin
                    if (!first_pulse) begin
                        n_assert++;
                        assert (on_len >= cur_min + 1) else begin
                            n_fail++;
                            $error("FAIL soak_min_on observed=%0d expected>=%0d", on_len, cur_min + 1);
                        end
                    end
                    first_pulse = 1'b0;
                    gap_exp     = (cur_dt == 0) ? 1 : cur_dt;
                    gap_len     = 1;
                    in_gap      = 1'b1;
                end else if (in_gap) begin
                    gap_len++;
                end
                prev_on = 1'b0;
            end
        end

        // reset mid-operation clears everything including drop_cnt
        rst = 1'b1;
        tick();
        check_outs("mid_rst", 1'b0, 1'b0);
        check("mid_rst_drop", {16'b0, drop_cnt}, 32'd0);
        check("mid_rst_fault", {31'b0, fault}, 32'd0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
